bcd_conv_scheduler: RTL and testbench



---
 rtl/bcd_conv_scheduler.sv | 137 +++++++++++++
 tb/tb_bcd_conv_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: one shared double-dabble converter, round-robin
// between score and combo channels, each producing packed 4-digit BCD.
// Ports: clock, rst (async high), score/combo (binary in), refresh,
//   score_bcd/combo_bcd (BCD out), score_valid/combo_valid (update
//   pulses), busy (converter in use), active_ch (0=score, 1=combo).
module bcd_conv_scheduler #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      score,
  input  logic [WIDTH-1:0]      combo,
  input  logic                  refresh,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   combo_bcd,
  output logic                  score_valid,
  output logic                  combo_valid,
  output logic                  busy,
  output logic                  active_ch
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] last_score;
  logic [WIDTH-1:0] last_combo;
  logic             pend_s;
  logic             pend_c;
  logic             last_grant;
  logic [WIDTH-1:0] operand;
  logic [BW-1:0]    bcd_acc;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    bit_cnt;

  logic mis_s;
  logic mis_c;
  logic req_s;
  logic req_c;
  logic grant_s;
  logic grant_c;

  assign mis_s = (score != last_score);
  assign mis_c = (combo != last_combo);
  assign req_s = pend_s | mis_s;
  assign req_c = pend_c | mis_c;

  // On a tie the channel not served last wins.
  assign grant_s = (state == IDLE) & req_s
                 & (~req_c | last_grant);
  assign grant_c = (state == IDLE) & req_c
                 & (~req_s | ~last_grant);

  // Add-3 correction on every nibble that is 5 or more.
  always_comb begin
    adj = bcd_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_acc[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_score  <= '0;
      last_combo  <= '0;
      pend_s      <= 1'b0;
      pend_c      <= 1'b0;
      last_grant  <= 1'b1;
      operand     <= '0;
      bcd_acc     <= '0;
      bit_cnt     <= '0;
      score_bcd   <= '0;
      combo_bcd   <= '0;
      score_valid <= 1'b0;
      combo_valid <= 1'b0;
      busy        <= 1'b0;
      active_ch   <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      combo_valid <= 1'b0;

      // A mismatch on the grant edge is consumed by the capture itself;
      // refresh on that edge still re-arms the flag.
      pend_s <= refresh | (mis_s & ~grant_s) | (pend_s & ~grant_s);
      pend_c <= refresh | (mis_c & ~grant_c) | (pend_c & ~grant_c);

      unique case (state)
        IDLE: begin
          if (grant_s | grant_c) begin
            if (grant_c) begin
              operand    <= combo;
              last_combo <= combo;
            end else begin
              operand    <= score;
              last_score <= score;
            end
            bcd_acc    <= '0;
            bit_cnt    <= '0;
            active_ch  <= grant_c;
            last_grant <= grant_c;
            busy       <= 1'b1;
            state      <= CONV;
          end
        end
        CONV: begin
          bcd_acc <= {adj[BW-2:0], operand[WIDTH-1]};
          operand <= {operand[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(WIDTH - 1))
            state <= DONE;
        end
        DONE: begin
          if (active_ch) begin
            combo_bcd   <= bcd_acc;
            combo_valid <= 1'b1;
          end else begin
            score_bcd   <= bcd_acc;
            score_valid <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb_bcd_conv_scheduler: directed vectors, per-channel expected queues,
// independent monitor comparing every valid pulse.
module tb_bcd_conv_scheduler;

  localparam int WIDTH = 10;

  logic             clock;
  logic             rst;
  logic [WIDTH-1:0] score;
  logic [WIDTH-1:0] combo;
  logic             refresh;
  logic [15:0]      score_bcd;
  logic [15:0]      combo_bcd;
  logic             score_valid;
  logic             combo_valid;
  logic             busy;
  logic             active_ch;

  bcd_conv_scheduler #(.WIDTH(WIDTH), .DIGITS(4)) dut (
    .clock       (clock),
    .rst         (rst),
    .score       (score),
    .combo       (combo),
    .refresh     (refresh),
    .score_bcd   (score_bcd),
    .combo_bcd   (combo_bcd),
    .score_valid (score_valid),
    .combo_valid (combo_valid),
    .busy        (busy),
    .active_ch   (active_ch)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int grant_cyc = 0;
  int s_pulses = 0;
  int c_pulses = 0;
  logic prev_busy = 1'b0;

  logic [15:0] qs[$];
  logic [15:0] qc[$];
  logic        glog[$];
  int          gcyc[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: busy rising marks a grant; each valid pulse is compared
  // against the head of that channel's queue and the grant latency.
  initial forever begin
    @(negedge clock);
    if (busy && !prev_busy) begin
      grant_cyc = cyc;
      glog.push_back(active_ch);
      gcyc.push_back(cyc);
    end
    prev_busy = busy;
    if (score_valid) begin
      s_pulses++;
      if (qs.size() == 0) begin
        chk("score_unexpected", 1, 0);
      end else begin
        chk("score_bcd", score_bcd, qs.pop_front());
      end
      chk("score_latency", cyc - grant_cyc, WIDTH + 1);
      chk("score_ch", active_ch, 0);
    end
    if (combo_valid) begin
      c_pulses++;
      if (qc.size() == 0) begin
        chk("combo_unexpected", 1, 0);
      end else begin
        chk("combo_bcd", combo_bcd, qc.pop_front());
      end
      chk("combo_latency", cyc - grant_cyc, WIDTH + 1);
      chk("combo_ch", active_ch, 1);
    end
  end

  task automatic drain();
    int idle_n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (qs.size() == 0 && qc.size() == 0 && !busy) idle_n++;
      else idle_n = 0;
      if (idle_n >= 3) return;
    end
    chk("drain_timeout", 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    repeat (2) @(negedge clock);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        ch;
    int          val;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   snap_s;
  int   snap_c;

  initial begin
    rst     = 1'b1;
    score   = '0;
    combo   = '0;
    refresh = 1'b0;
    vecs[0] = '{1'b0, 0,    16'h0000};
    vecs[1] = '{1'b1, 1,    16'h0001};
    vecs[2] = '{1'b0, 99,   16'h0099};
    vecs[3] = '{1'b1, 1000, 16'h1000};
    vecs[4] = '{1'b0, 640,  16'h0640};
    vecs[5] = '{1'b1, 0,    16'h0000};

    repeat (3) @(negedge clock);
    chk("rst_score_bcd", score_bcd, 0);
    chk("rst_combo_bcd", combo_bcd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active_ch", active_ch, 0);
    rst = 1'b0;

    // Zero inputs after reset: nothing to convert.
    repeat (6) @(negedge clock);
    chk("idle_busy", busy, 0);
    chk("idle_pulses", s_pulses + c_pulses, 0);
    chk("idle_score_bcd", score_bcd, 0);
    chk("idle_combo_bcd", combo_bcd, 0);

    // Single score conversion.
    score = 10'd937;
    qs.push_back(16'h0937);
    drain();
    chk("t2_score_bcd", score_bcd, 16'h0937);
    chk("t2_combo_bcd", combo_bcd, 0);
    chk("t2_pulses", s_pulses, 1);

    // Simultaneous change after reset: score first, then combo.
    @(negedge clock);
    rst   = 1'b1;
    score = '0;
    combo = '0;
    #1;
    chk("t3_rst_score_bcd", score_bcd, 0);
    repeat (2) @(negedge clock);
    rst = 1'b0;
    repeat (2) @(negedge clock);
    glog.delete();
    gcyc.delete();
    score = 10'd1023;
    combo = 10'd456;
    qs.push_back(16'h1023);
    qc.push_back(16'h0456);
    drain();
    chk("t3_grants", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("t3_first_ch", glog[0], 0);
      chk("t3_second_ch", glog[1], 1);
      chk("t3_spacing", gcyc[1] - gcyc[0], WIDTH + 2);
    end
    chk("t3_score_bcd", score_bcd, 16'h1023);
    chk("t3_combo_bcd", combo_bcd, 16'h0456);

    // Input change mid-conversion: old value first, then new one.
    snap_s = s_pulses;
    score = 10'd500;
    qs.push_back(16'h0500);
    repeat (4) @(negedge clock);
    score = 10'd501;
    qs.push_back(16'h0501);
    drain();
    chk("t4_pulses", s_pulses - snap_s, 2);
    chk("t4_score_bcd", score_bcd, 16'h0501);

    // Directed value table, including zero.
    foreach (vecs[i]) begin
      if (vecs[i].ch) begin
        combo = WIDTH'(vecs[i].val);
        qc.push_back(vecs[i].exp);
      end else begin
        score = WIDTH'(vecs[i].val);
        qs.push_back(vecs[i].exp);
      end
      drain();
    end

    // Refresh with unchanged inputs reconverts both once.
    score = 10'd42;
    combo = 10'd7;
    qs.push_back(16'h0042);
    qc.push_back(16'h0007);
    drain();
    snap_s = s_pulses;
    snap_c = c_pulses;
    refresh = 1'b1;
    qs.push_back(16'h0042);
    qc.push_back(16'h0007);
    @(negedge clock);
    refresh = 1'b0;
    drain();
    chk("t5_s_pulses", s_pulses - snap_s, 1);
    chk("t5_c_pulses", c_pulses - snap_c, 1);
    chk("t5_score_bcd", score_bcd, 16'h0042);
    chk("t5_combo_bcd", combo_bcd, 16'h0007);

    // Reset during a combo conversion aborts it.
    snap_c = c_pulses;
    combo = 10'd999;
    qc.push_back(16'h0999);
    repeat (6) @(negedge clock);
    rst = 1'b1;
    #1;
    chk("t6_score_bcd", score_bcd, 0);
    chk("t6_combo_bcd", combo_bcd, 0);
    chk("t6_busy", busy, 0);
    chk("t6_active_ch", active_ch, 0);
    repeat (3) @(negedge clock);
    chk("t6_no_pulse", c_pulses - snap_c, 0);
    rst = 1'b0;
    qs.push_back(16'h0042);
    drain();
    chk("t6_c_pulses", c_pulses - snap_c, 1);
    chk("t6_combo_bcd_after", combo_bcd, 16'h0999);
    chk("t6_score_bcd_after", score_bcd, 16'h0042);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
